// File: rtl/dmux_stream_pkg.sv
// Shared constants and helpers for the dmux_stream block.
package dmux_stream_pkg;

  // Width of the accepted-word counter.
  localparam int ACC_W = 16;

  // Ceiling log2, used to size the channel select (n >= 2 gives >= 1).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_stream_if.sv
// Stream bus of the demultiplexer: one input port, CH output channels.
//
// Handshake: a word moves across a port in a cycle where valid and ready are
// both 1 at the rising clock edge. in_ready never looks at in_valid, and a
// channel holds out_data stable while out_valid=1 and out_ready=0.
interface dmux_stream_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  import dmux_stream_pkg::*;

  localparam int SELW = clog2(CH);

  logic [WIDTH-1:0]    in_data;
  logic [SELW-1:0]     in_sel;
  logic                in_bcast;
  logic                in_valid;
  logic                in_ready;
  logic [CH*WIDTH-1:0] out_data;
  logic [CH-1:0]       out_valid;
  logic [CH-1:0]       out_ready;

  // Environment side: producer of input words and consumer of channels.
  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/dmux_slot.sv
// One-entry channel buffer: load wins over drain so a full channel can be
// refilled in the same cycle it is consumed.
module dmux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  // Full flag and data register; data only changes on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= data_in;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Stream demultiplexer: routes each accepted input word to one channel
// (unicast) or to all channels (broadcast). Out-of-range selects are
// accepted and dropped, raising a sticky error flag.
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmux_stream_if.slave     bus,
  output logic             err_sel,
  output logic [ACC_W-1:0] acc_cnt
);

  localparam int              SELW    = clog2(CH);
  localparam logic [SELW:0]   SEL_LIM = (SELW + 1)'(CH);

  logic [CH-1:0] free;
  logic [CH-1:0] load;
  logic          sel_ok;
  logic          sel_free;
  logic          accept;

  // A channel can take a word if it is empty or being drained this cycle.
  assign free   = ~bus.out_valid | bus.out_ready;
  assign sel_ok = {1'b0, bus.in_sel} < SEL_LIM;

  // Select decode, ready generation and per-channel load strobes.
  always_comb begin
    sel_free     = 1'b0;
    load         = '0;
    bus.in_ready = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (bus.in_sel == SELW'(i)) sel_free = free[i];
    end
    if (bus.in_bcast)  bus.in_ready = &free;
    else if (sel_ok)   bus.in_ready = sel_free;
    else               bus.in_ready = 1'b1;
    accept = bus.in_valid & bus.in_ready;
    for (int i = 0; i < CH; i++) begin
      load[i] = accept & (bus.in_bcast | (bus.in_sel == SELW'(i)));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_slot
    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .data_in   (bus.in_data),
      .ready_in  (bus.out_ready[g]),
      .valid_out (bus.out_valid[g]),
      .data_out  (bus.out_data[g*WIDTH +: WIDTH])
    );
  end

  // Sticky flag for an accepted unicast word with no matching channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_sel <= 1'b0;
    else if (accept & ~bus.in_bcast & ~sel_ok) err_sel <= 1'b1;
  end

  // Accepted-word counter; wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + ACC_W'(1);
  end

endmodule
